// File: rtl/regfile_sb.sv
// regfile_sb
//
// Multi-port integer register file with a per-register pending-bit scoreboard
// and a sequential clear engine. Register 0 is hard-wired to zero.
//
// Parameters:
//   XLEN  - register width in bits
//   NREGS - register count (power of two, >= 4)
//   NRD   - number of asynchronous read ports (>= 1)
//   AW    - address width, derived from NREGS
//
// Ports:
//   clk, reset      - clock; synchronous active-high reset
//   clr             - soft clear pulse; restarts the clear sweep
//   ready           - 1 when the file is usable (not resetting, not sweeping)
//   rd_addr         - NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data         - NRD packed read data, combinational
//   rd_busy         - pending bit of each addressed register, combinational
//   we0/wa0/wd0     - write port 0
//   we1/wa1/wd1     - write port 1 (wins on address collision)
//   rsv_en/rsv_addr - reserve request: marks rsv_addr pending
//
// Build option:
//   REGFILE_BYPASS_EN - when defined, reads forward same-cycle write data.

module regfile_sb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    output logic                 ready,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [AW-1:0]        wa0,
    input  logic [AW-1:0]        wa1,
    input  logic [XLEN-1:0]      wd0,
    input  logic [XLEN-1:0]      wd1,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [AW-1:0] IDX_FIRST = AW'(1);
    localparam logic [AW-1:0] IDX_LAST  = AW'(NREGS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     idx;
    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  pending_nxt;

    logic              restart;
    logic              usable;
    logic              sweep_we;
    logic              wr0_ok;
    logic              wr1_ok;
    logic              rsv_ok;

    // reset and clr are interchangeable: both restart the sweep at idx 1.
    assign restart  = reset | clr;

    // Outputs are forced quiet while reset is held, even before the first edge.
    assign usable   = (state == ST_READY) && !reset;

    assign sweep_we = (state == ST_CLEAR) && !restart;
    assign wr0_ok   = (state == ST_READY) && !restart && we0 && (wa0 != '0);
    assign wr1_ok   = (state == ST_READY) && !restart && we1 && (wa1 != '0);
    assign rsv_ok   = (state == ST_READY) && !restart && rsv_en && (rsv_addr != '0);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = usable;
        if (restart) begin
            state_nxt = ST_CLEAR;
        end else begin
            unique case (state)
                ST_CLEAR: if (idx == IDX_LAST) state_nxt = ST_READY;
                ST_READY: state_nxt = ST_READY;
                default:  state_nxt = ST_CLEAR;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sweep index
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (restart) begin
            idx <= IDX_FIRST;
        end else if (state == ST_CLEAR) begin
            idx <= idx + AW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Register storage (no reset: contents are zeroed by the sweep)
    // ------------------------------------------------------------------
    // Port 1 is assigned last so it wins when both ports hit one address.
    always_ff @(posedge clk) begin
        if (sweep_we) regs[idx] <= '0;
        if (wr0_ok)   regs[wa0] <= wd0;
        if (wr1_ok)   regs[wa1] <= wd1;
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    // Writes release, reservations set; a same-cycle reservation wins.
    always_comb begin
        pending_nxt = pending;
        if (wr0_ok) pending_nxt[wa0] = 1'b0;
        if (wr1_ok) pending_nxt[wa1] = 1'b0;
        if (rsv_ok) pending_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            pending <= '0;
        end else if (state == ST_READY) begin
            pending <= pending_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr = rd_addr[k*AW +: AW];

        always_comb begin
            data = '0;
            busy = 1'b0;
            if (usable && (addr != '0)) begin
                data = regs[addr];
                busy = pending[addr];
`ifdef REGFILE_BYPASS_EN
                // A forwarded register is being written, so it reads as
                // released unless a reservation lands on it this cycle.
                if (wr0_ok && (wa0 == addr)) begin
                    data = wd0;
                    busy = rsv_ok && (rsv_addr == addr);
                end
                if (wr1_ok && (wa1 == addr)) begin
                    data = wd1;
                    busy = rsv_ok && (rsv_addr == addr);
                end
`endif
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data;
        assign rd_busy[k]              = busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned AW    = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic                clr;
    logic                ready;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                we0, we1;
    logic [AW-1:0]       wa0, wa1;
    logic [XLEN-1:0]     wd0, wd1;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;

    int tests = 0;
    int fails = 0;

    // Reference model: register values, pending bits, edges left in sweep.
    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_pend [NREGS];
    int              m_left = NREGS - 1;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk(clk), .reset(reset), .clr(clr), .ready(ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    always #5 clk = ~clk;

    // Advance one edge, applying the architectural rules to the model using
    // the inputs present before the edge; returns 1ns after the edge.
    task automatic tick();
        if (reset || clr) begin
            m_left = NREGS - 1;
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
        end else if (m_left > 0) begin
            m_left--;
        end else begin
            if (we0 && wa0 != 0) begin m_regs[wa0] = wd0; m_pend[wa0] = 1'b0; end
            if (we1 && wa1 != 0) begin m_regs[wa1] = wd1; m_pend[wa1] = 1'b0; end
            if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 0; we0 = 0; we1 = 0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        rsv_en = 0; rsv_addr = '0;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    function automatic logic exp_ready();
        return (m_left == 0) && !reset;
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        if (!exp_ready() || a == 0) return '0;
        v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
        if (!clr && we0 && wa0 == a) v = wd0;
        if (!clr && we1 && wa1 == a) v = wd1;
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (!exp_ready() || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (!clr && ((we0 && wa0 == a) || (we1 && wa1 == a)))
            return rsv_en && rsv_addr == a;
`endif
        return m_pend[a];
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        int n;
        idle_inputs();
        rd_addr = '0;
        reset = 1; we0 = 1; wa0 = 5'd3; wd0 = 32'hAA;
        #1;
        tests++;
        if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready_pre got=%b exp=0", ready); end
        tick();
        tick();
        tests++;
        if (ready !== 1'b0 || rd_data !== '0 || rd_busy !== '0) begin
            fails++; $display("FAIL reset_outputs ready=%b data=%h busy=%b exp 0/0/0", ready, rd_data, rd_busy);
        end
        reset = 0;
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (ready === 1'b1) break;
        end
        we0 = 0;
        tests++;
        if (n != 31) begin fails++; $display("FAIL reset_sweep_len got=%0d exp=31", n); end
        for (int i = 0; i < NREGS; i++) begin
            set_rd(0, AW'(i)); set_rd(1, AW'(NREGS - 1 - i));
            #1;
            tests++;
            if (rd_data !== '0 || rd_busy !== '0) begin
                fails++; $display("FAIL reset_zero reg=%0d data=%h busy=%b exp 0", i, rd_data, rd_busy);
            end
        end
    endtask

    task automatic test_collision();
        idle_inputs();
        we0 = 1; we1 = 1; wa0 = 5'd5; wa1 = 5'd5; wd0 = 32'h11; wd1 = 32'h22;
        tick();
        idle_inputs();
        set_rd(0, 5'd5); set_rd(1, 5'd5);
        #1;
        tests++;
        if (rd_data[31:0] !== 32'h22 || rd_data[63:32] !== 32'h22) begin
            fails++; $display("FAIL collision got=%h exp=22 both ports", rd_data);
        end
        we0 = 1; wa0 = 5'd0; wd0 = 32'hFF;
        tick();
        idle_inputs();
        set_rd(0, 5'd0);
        #1;
        tests++;
        if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            fails++; $display("FAIL reg0_write got=%h busy=%b exp=0/0", rd_data[31:0], rd_busy[0]);
        end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        set_rd(0, 5'd9); set_rd(1, 5'd7);
        rsv_en = 1; rsv_addr = 5'd9;
        tick();
        idle_inputs();
        #1;
        tests++;
        if (rd_busy[0] !== 1'b1) begin fails++; $display("FAIL rsv_busy got=%b exp=1", rd_busy[0]); end
        we1 = 1; wa1 = 5'd9; wd1 = 32'h1000;
        tick();
        idle_inputs();
        #1;
        tests++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h1000) begin
            fails++; $display("FAIL release got busy=%b data=%h exp 0/1000", rd_busy[0], rd_data[31:0]);
        end
        rsv_en = 1; rsv_addr = 5'd7; we0 = 1; wa0 = 5'd7; wd0 = 32'h77;
        tick();
        idle_inputs();
        #1;
        tests++;
        if (rd_busy[1] !== 1'b1 || rd_data[63:32] !== 32'h77) begin
            fails++; $display("FAIL rsv_and_write got busy=%b data=%h exp 1/77", rd_busy[1], rd_data[63:32]);
        end
        rsv_en = 1; rsv_addr = 5'd7;
        tick();
        idle_inputs();
        #1;
        tests++;
        if (rd_busy[1] !== 1'b1) begin fails++; $display("FAIL rsv_again got=%b exp=1", rd_busy[1]); end
    endtask

    task automatic test_bypass();
        idle_inputs();
        we0 = 1; wa0 = 5'd6; wd0 = 32'h5;
        tick();
        idle_inputs();
        set_rd(0, 5'd6);
        we0 = 1; wa0 = 5'd6; wd0 = 32'h6;
        #1;
        tests++;
`ifdef REGFILE_BYPASS_EN
        if (rd_data[31:0] !== 32'h6) begin fails++; $display("FAIL bypass_same got=%h exp=6", rd_data[31:0]); end
`else
        if (rd_data[31:0] !== 32'h5) begin fails++; $display("FAIL nobypass_same got=%h exp=5", rd_data[31:0]); end
`endif
        tick();
        idle_inputs();
        #1;
        tests++;
        if (rd_data[31:0] !== 32'h6) begin fails++; $display("FAIL write_next got=%h exp=6", rd_data[31:0]); end
    endtask

    task automatic test_clr_mid_sweep();
        int n;
        idle_inputs();
        rsv_en = 1; rsv_addr = 5'd2;
        tick();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < 9; i++) tick();
        clr = 1;
        tick();
        clr = 0;
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (ready === 1'b1) break;
        end
        tests++;
        if (n != 31) begin fails++; $display("FAIL clr_sweep_len got=%0d exp=31", n); end
        for (int i = 0; i < NREGS; i++) begin
            set_rd(0, AW'(i));
            #1;
            tests++;
            if (rd_busy[0] !== 1'b0) begin fails++; $display("FAIL clr_pending reg=%0d got=%b exp=0", i, rd_busy[0]); end
        end
    endtask

    task automatic test_reset_midop();
        int n;
        idle_inputs();
        for (int r = 1; r <= 4; r++) begin
            rsv_en = 1; rsv_addr = AW'(r);
            tick();
        end
        idle_inputs();
        set_rd(0, 5'd3); set_rd(1, 5'd4);
        #1;
        tests++;
        if (rd_busy !== 2'b11) begin fails++; $display("FAIL midop_rsv got=%b exp=11", rd_busy); end
        reset = 1;
        tick();
        reset = 0;
        #1;
        tests++;
        if (rd_busy !== 2'b00 || ready !== 1'b0) begin
            fails++; $display("FAIL midop_reset busy=%b ready=%b exp 00/0", rd_busy, ready);
        end
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (ready === 1'b1) break;
        end
        tests++;
        if (n != 31) begin fails++; $display("FAIL midop_sweep_len got=%0d exp=31", n); end
        tests++;
        if (rd_busy !== 2'b00) begin fails++; $display("FAIL midop_pending got=%b exp=00", rd_busy); end
    endtask

    task automatic test_random();
        int nbad = 0;
        for (int c = 0; c < 600; c++) begin
            clr      = ($urandom_range(0, 99) == 0);
            we0      = $urandom_range(0, 1);
            we1      = $urandom_range(0, 1);
            wa0      = AW'($urandom_range(0, 7));
            wa1      = AW'($urandom_range(0, 7));
            wd0      = $urandom;
            wd1      = $urandom;
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = AW'($urandom_range(0, 7));
            for (int k = 0; k < NRD; k++) set_rd(k, AW'($urandom_range(0, 7)));
            #1;
            tests++;
            if (ready !== exp_ready()) begin
                fails++;
                if (nbad++ < 10) $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, ready, exp_ready());
            end
            for (int k = 0; k < NRD; k++) begin
                tests++;
                if (rd_data[k*XLEN +: XLEN] !== exp_data(rd_addr[k*AW +: AW]) ||
                    rd_busy[k] !== exp_busy(rd_addr[k*AW +: AW])) begin
                    fails++;
                    if (nbad++ < 10)
                        $display("FAIL rand_read cyc=%0d port=%0d addr=%0d got=%h/%b exp=%h/%b", c, k,
                                 rd_addr[k*AW +: AW], rd_data[k*XLEN +: XLEN], rd_busy[k],
                                 exp_data(rd_addr[k*AW +: AW]), exp_busy(rd_addr[k*AW +: AW]));
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        rd_addr = '0;
        #2;
        test_reset();
        test_collision();
        test_scoreboard();
        test_bypass();
        test_clr_mid_sweep();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with a per-register scoreboard and a sequential clear engine. It serves as the architectural register file of the RV32 core and its multi-cycle variants. It provides NRD asynchronous read ports and two synchronous write ports. Each register carries a pending bit that issue logic reserves and writeback releases, so hazard detection lives next to the data.

## Interface
- XLEN, 32: register width in bits.
- NREGS, 32: register count; power of two, ≥ 4; register 0 is hard-wired zero.
- NRD, 2: number of read ports, ≥ 1.
- AW, $clog2(NREGS): address width (derived, not overridden).

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- clr  in  1  soft-clear request (single-cycle pulse), starts a clear sweep.
- ready  out  1  1 when the file is usable; 0 during reset and during a sweep.
- rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data, combinational.
- rd_busy  out  NRD  pending bit of each addressed register, combinational.
- we0, we1  in  1  write enables.
- wa0, wa1  in  AW  write addresses.
- wd0, wd1  in  XLEN  write data.
- rsv_en  in  1  reserve request.
- rsv_addr  in  AW  register to mark pending.

## Operation
The FSM has two states: CLEAR and READY.

- **reset = 1:** the state goes to CLEAR, idx = 1, and all pending bits are cleared. Register contents are left untouched.
- **CLEAR, each edge:** REG[idx] ← 0 and idx++. When idx == NREGS-1 is cleared, the state goes to READY.
  - Writes and reservations are ignored.
  - rd_data = 0 and rd_busy = 0 on all ports.
  - ready = 0.
- **clr = 1:** behaves exactly like reset, in any state.
  - In READY it has priority over writes and reservations in the same cycle; those are dropped.
  - In CLEAR it restarts the sweep at idx = 1.
- **READY writes:**
  - A write with weN = 1 and waN ≠ 0 updates REG[waN] at the edge. Writes to address 0 are discarded.
  - If wa0 == wa1 with both enabled, port 1 wins.
  - A write clears the pending bit of its address.
- **READY reservation:**
  - With rsv_en = 1 and rsv_addr ≠ 0, the pending bit of rsv_addr is set at the edge.
  - If a reservation and a write target the same register in the same cycle, the reservation wins: the data is written and the pending bit ends up 1.
  - Reserving an already-pending register is legal; the bit stays 1.
- **Reads:**
  - An address of 0 returns 0 with busy = 0.
  - Otherwise the read returns REG[addr] and pending[addr].
  - Read ports are independent; any number may alias the same register.
- Out-of-range addresses cannot occur because NREGS is a power of two.

## Timing
- Write-to-read latency is 1 edge without bypass (see Configuration) and 0 with bypass.
- Reservation is visible on rd_busy 1 edge after it is applied.
- Sweep length is NREGS-1 edges after the last edge with reset (or clr) sampled high. For NREGS = 32, ready rises 31 edges after reset deasserts.
- Output values during reset: ready = 0, rd_data = 0, rd_busy = 0.
- Register contents are undefined before the first completed sweep.

## Configuration
- **REGFILE_BYPASS_EN defined:** in READY, a read port whose address matches an enabled write this cycle returns the write data combinationally. Port 1 data is returned if both ports match.
  - rd_busy shows 0 for that register, unless rsv_en targets the same address this cycle, in which case it shows 1.
- **REGFILE_BYPASS_EN undefined:** reads return the pre-edge REG and pending values; there is no combinational path from the write or reservation inputs to the outputs.

## Test plan
- **Reset sweep.** Stimulus: NREGS = 32; pulse reset for 2 cycles, hold we0 = 1, wa0 = 3, wd0 = 0xAA throughout. Required: ready = 0 for 31 edges then 1; afterwards every register reads 0, and register 3 is not 0xAA.
- **Dual write collision.** Stimulus: we0 = we1 = 1, wa0 = wa1 = 5, wd0 = 0x11, wd1 = 0x22. Required: the next cycle reads 0x22.
  - Also write wa0 = 0, wd0 = 0xFF; register 0 still reads 0.
- **Scoreboard.** Stimulus: rsv reg 9; then write reg 9 = 0x1000. Required: rd_busy = 1 in the cycle after the reserve, 0 after the write, and data = 0x1000.
  - Simultaneous rsv and write of reg 7 leaves busy = 1 with the data updated.
- **Bypass (macro on).** Stimulus: write reg 6 = 0x6 while rd_addr[0] = 6. Required: rd_data[0] = 0x6 in the same cycle.
  - Macro off: the old value is returned in the same cycle, and 0x6 is returned next cycle.
- **Soft clear mid-sweep.** Stimulus: reset, then assert clr at sweep edge 10. Required: ready rises 31 edges after the clr edge, and all pending bits are 0.
- **Reset mid-operation.** Stimulus: reserve regs 1–4, then assert reset. Required: rd_busy = 0 immediately after the reset edge, and ready is 0 until the sweep completes.
